// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results (1-entry hold) and load results (FIFO) into one registered register-file write per cycle, 2-cycle latency.
// Backpressure via alu_ready/ld_ready; define WB_PENDING_EN to add the pending_mask hazard output.
module reg_writeback #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int LQ_DEPTH     = 4,
  parameter int ALU_MAX_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic              alu_sp,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic              ld_sp,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0] Write_d,
  output logic              Use_SP,
`ifdef WB_PENDING_EN
  output logic [31:0]       pending_mask,
`endif
  output logic              wb_busy
);
  localparam int PTR_W  = $clog2(LQ_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (ALU_MAX_WAIT < 1) ? 1 : $clog2(ALU_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  LQ_FULL  = CNT_W'(LQ_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ALU_MAX_WAIT);
  localparam logic [ADDR_W-1:0] REG31    = ADDR_W'(31);

  logic              hold_valid;
  logic [ADDR_W-1:0] hold_rd;
  logic              hold_sp;
  logic [DATA_W-1:0] hold_data;
  logic [WAIT_W-1:0] wait_cnt;

  logic [ADDR_W-1:0] lq_rd   [LQ_DEPTH];
  logic              lq_sp   [LQ_DEPTH];
  logic [DATA_W-1:0] lq_data [LQ_DEPTH];
  logic [PTR_W-1:0]  lq_wr_ptr;
  logic [PTR_W-1:0]  lq_rd_ptr;
  logic [CNT_W-1:0]  lq_count;

  logic              alu_fire;
  logic              ld_fire;
  logic              lq_empty;
  logic              hold_win;
  logic              lq_win;
  logic [ADDR_W-1:0] win_rd;
  logic              win_sp;
  logic [DATA_W-1:0] win_data;

  function automatic logic is_xzr(input logic [ADDR_W-1:0] rd, input logic sp);
    return (rd == REG31) && !sp;
  endfunction

  assign alu_ready = !rst && !hold_valid;
  assign ld_ready  = !rst && (lq_count != LQ_FULL);
  assign alu_fire  = alu_valid && alu_ready;
  assign ld_fire   = ld_valid && ld_ready;
  assign wb_busy   = hold_valid || (lq_count != '0);

  // Loads win by default; the hold only wins when starved long enough or unopposed.
  assign lq_empty = (lq_count == '0);
  assign hold_win = hold_valid && ((wait_cnt == WAIT_MAX) || lq_empty);
  assign lq_win   = !lq_empty && !hold_win;

  always_comb begin
    win_rd   = lq_rd[lq_rd_ptr];
    win_sp   = lq_sp[lq_rd_ptr];
    win_data = lq_data[lq_rd_ptr];
    if (hold_win) begin
      win_rd   = hold_rd;
      win_sp   = hold_sp;
      win_data = hold_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      lq_rd[lq_wr_ptr]   <= ld_rd;
      lq_sp[lq_wr_ptr]   <= ld_sp;
      lq_data[lq_wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid     <= 1'b0;
      hold_rd        <= '0;
      hold_sp        <= 1'b0;
      hold_data      <= '0;
      wait_cnt       <= '0;
      lq_wr_ptr      <= '0;
      lq_rd_ptr      <= '0;
      lq_count       <= '0;
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_d        <= '0;
      Use_SP         <= 1'b0;
    end else begin
      // alu_ready excludes a valid hold, so fill and drain never coincide.
      if (alu_fire) begin
        hold_valid <= 1'b1;
        hold_rd    <= alu_rd;
        hold_sp    <= alu_sp;
        hold_data  <= alu_data;
      end else if (hold_win) begin
        hold_valid <= 1'b0;
      end

      if (hold_win) begin
        wait_cnt <= '0;
      end else if (hold_valid && lq_win && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      if (ld_fire) lq_wr_ptr <= lq_wr_ptr + PTR_W'(1);
      if (lq_win)  lq_rd_ptr <= lq_rd_ptr + PTR_W'(1);
      lq_count <= lq_count + CNT_W'(ld_fire) - CNT_W'(lq_win);

      if (hold_win || lq_win) begin
        RegWrite       <= !is_xzr(win_rd, win_sp);
        Write_register <= win_rd;
        Write_d        <= win_data;
        Use_SP         <= (win_rd == REG31) && win_sp;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

`ifdef WB_PENDING_EN
  // A FIFO slot is live when its distance from the read pointer is below the count.
  always_comb begin
    pending_mask = '0;
    if (hold_valid && !is_xzr(hold_rd, hold_sp)) pending_mask[hold_rd] = 1'b1;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (({1'b0, PTR_W'(i) - lq_rd_ptr} < lq_count) && !is_xzr(lq_rd[i], lq_sp[i]))
        pending_mask[lq_rd[i]] = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: fixed vector table, hand-written corner sequences, then random traffic against a queue-based model.
module tb_reg_writeback;
  localparam int DATA_W       = 64;
  localparam int ADDR_W       = 5;
  localparam int LQ_DEPTH     = 4;
  localparam int ALU_MAX_WAIT = 2;

  logic              clk;
  logic              rst;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic              alu_sp;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_rd;
  logic              ld_sp;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] Write_d;
  logic              Use_SP;
  logic              wb_busy;
`ifdef WB_PENDING_EN
  logic [31:0]       pending_mask;
`endif

  reg_writeback #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LQ_DEPTH(LQ_DEPTH), .ALU_MAX_WAIT(ALU_MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_sp(alu_sp), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_sp(ld_sp), .ld_data(ld_data), .ld_ready(ld_ready),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_d(Write_d), .Use_SP(Use_SP),
`ifdef WB_PENDING_EN
    .pending_mask(pending_mask),
`endif
    .wb_busy(wb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: load queue, one-slot hold, consecutive-loss counter.
  typedef struct packed {
    logic [4:0]  rd;
    logic        sp;
    logic [63:0] data;
  } res_t;

  res_t        lq[$];
  bit          m_hold;
  res_t        m_h;
  int          m_wait;
  bit          m_rw;
  logic [4:0]  m_wr;
  logic [63:0] m_wd;
  bit          m_usp;
  bit          m_def;

  task automatic model_step();
    res_t w;
    bit   has;
    bit   a_acc;
    bit   l_acc;
    if (rst) begin
      lq.delete();
      m_hold = 0; m_wait = 0;
      m_rw = 0; m_wr = '0; m_wd = '0; m_usp = 0; m_def = 1;
      return;
    end
    a_acc = alu_valid && !m_hold;
    l_acc = ld_valid && (lq.size() < LQ_DEPTH);
    has = 0;
    w = '0;
    if (m_hold && (m_wait == ALU_MAX_WAIT || lq.size() == 0)) begin
      w = m_h; m_hold = 0; m_wait = 0; has = 1;
    end else if (lq.size() != 0) begin
      w = lq.pop_front(); has = 1;
      if (m_hold && m_wait < ALU_MAX_WAIT) m_wait++;
    end
    if (a_acc) begin m_h = '{alu_rd, alu_sp, alu_data}; m_hold = 1; end
    if (l_acc) lq.push_back('{ld_rd, ld_sp, ld_data});
    if (has) begin
      m_rw  = !(w.rd == 5'd31 && !w.sp);
      m_wr  = w.rd;
      m_wd  = w.data;
      m_usp = (w.rd == 5'd31) && w.sp;
      m_def = m_rw;
    end else begin
      m_rw = 0;
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    if (m_hold && !(m_h.rd == 5'd31 && !m_h.sp)) m[m_h.rd] = 1'b1;
    foreach (lq[i]) if (!(lq[i].rd == 5'd31 && !lq[i].sp)) m[lq[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic cmp_model(input string tag);
    chk({tag, ".RegWrite"}, 64'(RegWrite), 64'(m_rw));
    if (m_def) begin
      chk({tag, ".Write_register"}, 64'(Write_register), 64'(m_wr));
      chk({tag, ".Write_d"}, Write_d, m_wd);
      chk({tag, ".Use_SP"}, 64'(Use_SP), 64'(m_usp));
    end
    chk({tag, ".wb_busy"}, 64'(wb_busy), 64'(m_hold || lq.size() != 0));
    chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(!rst && !m_hold));
    chk({tag, ".ld_ready"}, 64'(ld_ready), 64'(!rst && lq.size() < LQ_DEPTH));
`ifdef WB_PENDING_EN
    chk({tag, ".pending_mask"}, 64'(pending_mask), 64'(model_mask()));
`endif
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic asp,
                       input logic [63:0] ad, input logic lv, input logic [4:0] lrd,
                       input logic lsp, input logic [63:0] ldd);
    rst = r; alu_valid = av; alu_rd = ard; alu_sp = asp; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_sp = lsp; ld_data = ldd;
    @(posedge clk);
    #1;
    model_step();
  endtask

  typedef struct {
    logic rst; logic av; logic [4:0] ard; logic asp; logic [63:0] ad;
    logic lv; logic [4:0] lrd; logic lsp; logic [63:0] ldd;
    logic rw; logic [4:0] wr; logic [63:0] wd; logic usp; logic chk_out;
    logic busy; logic ardy; logic lrdy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard, input logic asp,
                              input logic [63:0] ad, input logic lv, input logic [4:0] lrd,
                              input logic lsp, input logic [63:0] ldd, input logic rw,
                              input logic [4:0] wr, input logic [63:0] wd, input logic usp,
                              input logic co, input logic busy, input logic ardy, input logic lrdy);
    vec_t v;
    v = '{r, av, ard, asp, ad, lv, lrd, lsp, ldd, rw, wr, wd, usp, co, busy, ardy, lrdy};
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bit seen_full;
    rst = 1; alu_valid = 0; alu_rd = '0; alu_sp = 0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_sp = 0; ld_data = '0;

    //           rst av ard asp ad        lv lrd lsp ldd        rw wr  wd        usp chk busy ardy lrdy
    tbl.push_back(mk(1, 0, 0, 0, 0,        0, 0, 0, 0,        0, 0,  0,        0, 1,  0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 'h1234,   0, 0, 0, 0,        0, 0,  0,        0, 1,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0, 0,        1, 3,  'h1234,   0, 1,  0, 1, 1));
    tbl.push_back(mk(0, 1, 31, 0, 'hFF,    0, 0, 0, 0,        0, 3,  'h1234,   0, 1,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0, 0,        0, 31, 'hFF,     0, 0,  0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 31, 1, 'h8000,  0, 31, 'hFF,     0, 0,  1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0, 0,        1, 31, 'h8000,   1, 1,  0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0, 0,        0, 31, 'h8000,   1, 1,  0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 1, 0, 'h101,    0, 31, 'h8000,   1, 1,  1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 2, 0, 'h102,    1, 1,  'h101,    0, 1,  1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 3, 0, 'h103,    1, 2,  'h102,    0, 1,  1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 4, 0, 'h104,    1, 3,  'h103,    0, 1,  1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0, 0,        1, 4,  'h104,    0, 1,  0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0, 0,        0, 4,  'h104,    0, 1,  0, 1, 1));
    // ALU rd9 loses twice to a steady load stream, then wins.
    tbl.push_back(mk(0, 1, 9, 0, 'h909,    1, 10, 0, 'h10A,   0, 4,  'h104,    0, 1,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 11, 0, 'h10B,   1, 10, 'h10A,    0, 1,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 12, 0, 'h10C,   1, 11, 'h10B,    0, 1,  1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        1, 13, 0, 'h10D,   1, 9,  'h909,    0, 1,  1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0, 0,        1, 12, 'h10C,    0, 1,  1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0, 0,        1, 13, 'h10D,    0, 1,  0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,        0, 0, 0, 0,        0, 13, 'h10D,    0, 1,  0, 1, 1));

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("tbl%0d", i);
      drive(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].asp, tbl[i].ad,
            tbl[i].lv, tbl[i].lrd, tbl[i].lsp, tbl[i].ldd);
      chk({t, ".RegWrite"}, 64'(RegWrite), 64'(tbl[i].rw));
      if (tbl[i].chk_out) begin
        chk({t, ".Write_register"}, 64'(Write_register), 64'(tbl[i].wr));
        chk({t, ".Write_d"}, Write_d, tbl[i].wd);
        chk({t, ".Use_SP"}, 64'(Use_SP), 64'(tbl[i].usp));
      end
      chk({t, ".wb_busy"}, 64'(wb_busy), 64'(tbl[i].busy));
      chk({t, ".alu_ready"}, 64'(alu_ready), 64'(tbl[i].ardy));
      chk({t, ".ld_ready"}, 64'(ld_ready), 64'(tbl[i].lrdy));
    end

`ifdef WB_PENDING_EN
    drive(0, 1, 7, 0, 'h777, 1, 5, 0, 'h555);
    chk("pend_both", 64'(pending_mask), 64'h0000_00A0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pend_one", 64'(pending_mask), 64'h0000_0080);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pend_none", 64'(pending_mask), 64'h0);
`endif

    // Saturate both paths until the load FIFO fills, then reset with work pending.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    seen_full = 0;
    for (int i = 0; i < 13; i++) begin
      drive(0, 1, 5'(16 + i), 0, 64'(32'hA000 + i), 1, 5'(i + 1), 0, 64'(32'hB000 + i));
      cmp_model($sformatf("sat%0d", i));
      if (!ld_ready) seen_full = 1;
    end
    chk("fifo_full_seen", 64'(seen_full), 64'd1);
    chk("busy_before_rst", 64'(wb_busy), 64'd1);
    drive(1, 1, 3, 0, 'h33, 1, 4, 0, 'h44);
    chk("rst.RegWrite", 64'(RegWrite), 64'd0);
    chk("rst.Write_register", 64'(Write_register), 64'd0);
    chk("rst.Write_d", Write_d, 64'd0);
    chk("rst.Use_SP", 64'(Use_SP), 64'd0);
    chk("rst.wb_busy", 64'(wb_busy), 64'd0);
    chk("rst.alu_ready", 64'(alu_ready), 64'd0);
    chk("rst.ld_ready", 64'(ld_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("post_rst%0d.RegWrite", i), 64'(RegWrite), 64'd0);
      chk($sformatf("post_rst%0d.wb_busy", i), 64'(wb_busy), 64'd0);
      chk($sformatf("post_rst%0d.alu_ready", i), 64'(alu_ready), 64'd1);
      chk($sformatf("post_rst%0d.ld_ready", i), 64'(ld_ready), 64'd1);
    end

    // Random traffic with varying load/ALU pressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int  pa;
      int  pl;
      logic [4:0] ra;
      logic [4:0] rl;
      pa = (i / 500) % 3 == 0 ? 90 : 40;
      pl = (i / 300) % 2 == 0 ? 95 : 30;
      ra = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      rl = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < pa, ra, 1'($urandom), {$urandom, $urandom},
            $urandom_range(0, 99) < pl, rl, 1'($urandom), {$urandom, $urandom});
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
